axis_pair_adder: RTL and testbench

//  NoC compute endpoint that receives single-flit operand packets from two generator nodes.

---
 rtl/axis_pair_adder.sv | 168 ++++++++++++++++
 tb/tb_axis_pair_adder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pair_adder.sv
// Pairs signed operands from two NoC sources in arrival order and emits their sum as a single-flit packet.
// Define ADDER_SATURATE_EN to clamp overflowing sums instead of wrapping them.
module axis_pair_adder #(
  parameter int TDATAW      = 32,
  parameter int TDESTW      = 4,
  parameter int TIDW        = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SRC_A_ID    = 0,
  parameter int SRC_B_ID    = 2,
  parameter int RESULT_DEST = 3,
  parameter int NODE_ID     = 1,
  parameter int NUM_PACKETS = 16,
  parameter int CNTW        = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TIDW-1:0]   AXIS_S_TID,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TIDW-1:0]   AXIS_M_TID,
  output logic [TDESTW-1:0] AXIS_M_TDEST,
  output logic [CNTW-1:0]   RESULT_CNT,
  output logic [CNTW-1:0]   DROP_CNT,
  output logic              OVF
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e state_q, state_d;

  logic signed [TDATAW-1:0] fifo_a_q [FIFO_DEPTH];
  logic signed [TDATAW-1:0] fifo_b_q [FIFO_DEPTH];
  logic [AW:0] wr_a_q, rd_a_q, wr_b_q, rd_b_q;
  logic [AW:0] wr_a_d, rd_a_d, wr_b_d, rd_b_d;
  logic        s_tready_q, s_tready_d;

  logic signed [TDATAW-1:0] m_tdata_q;
  logic                     m_tlast_q;
  logic [BW-1:0]            burst_q, burst_nxt, load_idx;
  logic [CNTW-1:0]          result_cnt_q, drop_cnt_q;
  logic                     ovf_q;

  logic s_hs, m_hs, push_a, push_b, drop, pop, pair_rdy;
  logic signed [TDATAW-1:0] a_head, b_head, sum_wrap, sum_res;
  logic ovf_now;
  logic unused_inputs;

  assign unused_inputs = ^{AXIS_S_TLAST, AXIS_S_TDEST};

`ifdef ADDER_SATURATE_EN
  function automatic logic signed [TDATAW-1:0] saturate(input logic signed [TDATAW-1:0] wrapped,
                                                        input logic ovf, input logic a_neg);
    if (!ovf) return wrapped;
    return a_neg ? {1'b1, {(TDATAW-1){1'b0}}} : {1'b0, {(TDATAW-1){1'b1}}};
  endfunction
`endif

  assign s_hs   = AXIS_S_TVALID && s_tready_q;
  assign push_a = s_hs && (AXIS_S_TID == TIDW'(SRC_A_ID));
  assign push_b = s_hs && (AXIS_S_TID == TIDW'(SRC_B_ID));
  assign drop   = s_hs && !push_a && !push_b;
  assign m_hs   = (state_q == SEND) && AXIS_M_TREADY;

  assign pair_rdy = (wr_a_q != rd_a_q) && (wr_b_q != rd_b_q);
  assign a_head   = fifo_a_q[rd_a_q[AW-1:0]];
  assign b_head   = fifo_b_q[rd_b_q[AW-1:0]];
  assign sum_wrap = a_head + b_head;
  assign ovf_now  = (a_head[TDATAW-1] == b_head[TDATAW-1]) && (sum_wrap[TDATAW-1] != a_head[TDATAW-1]);
`ifdef ADDER_SATURATE_EN
  assign sum_res  = saturate(sum_wrap, ovf_now, a_head[TDATAW-1]);
`else
  assign sum_res  = sum_wrap;
`endif

  assign burst_nxt = (burst_q == BW'(NUM_PACKETS-1)) ? '0 : burst_q + BW'(1);
  // A result loaded during a handshake belongs to the next burst slot.
  assign load_idx  = m_hs ? burst_nxt : burst_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pair_rdy) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_hs) begin
          if (pair_rdy) pop = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is computed from next-cycle fullness, so a same-cycle pop never frees a full FIFO early.
  always_comb begin
    wr_a_d     = wr_a_q + (AW+1)'(push_a);
    wr_b_d     = wr_b_q + (AW+1)'(push_b);
    rd_a_d     = rd_a_q + (AW+1)'(pop);
    rd_b_d     = rd_b_q + (AW+1)'(pop);
    s_tready_d = ((wr_a_d ^ rd_a_d) != {1'b1, {AW{1'b0}}}) &&
                 ((wr_b_d ^ rd_b_d) != {1'b1, {AW{1'b0}}});
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      wr_a_q       <= '0;
      rd_a_q       <= '0;
      wr_b_q       <= '0;
      rd_b_q       <= '0;
      s_tready_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tlast_q    <= 1'b0;
      burst_q      <= '0;
      result_cnt_q <= '0;
      drop_cnt_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_a_q     <= wr_a_d;
      rd_a_q     <= rd_a_d;
      wr_b_q     <= wr_b_d;
      rd_b_q     <= rd_b_d;
      s_tready_q <= s_tready_d;
      if (pop) begin
        m_tdata_q <= sum_res;
        m_tlast_q <= (load_idx == BW'(NUM_PACKETS-1));
        if (ovf_now) ovf_q <= 1'b1;
      end
      if (m_hs) begin
        burst_q      <= burst_nxt;
        result_cnt_q <= result_cnt_q + CNTW'(1);
      end
      if (drop && (drop_cnt_q != {CNTW{1'b1}})) drop_cnt_q <= drop_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_a) fifo_a_q[wr_a_q[AW-1:0]] <= AXIS_S_TDATA;
    if (push_b) fifo_b_q[wr_b_q[AW-1:0]] <= AXIS_S_TDATA;
  end

  assign AXIS_S_TREADY = s_tready_q;
  assign AXIS_M_TVALID = (state_q == SEND);
  assign AXIS_M_TDATA  = m_tdata_q;
  assign AXIS_M_TLAST  = m_tlast_q;
  assign AXIS_M_TID    = TIDW'(NODE_ID);
  assign AXIS_M_TDEST  = TDESTW'(RESULT_DEST);
  assign RESULT_CNT    = result_cnt_q;
  assign DROP_CNT      = drop_cnt_q;
  assign OVF           = ovf_q;

endmodule

// File: tb/tb_axis_pair_adder.sv
// Bench for axis_pair_adder: table-driven pairs plus hand-written stall, drop, overflow and reset sequences.
module tb_axis_pair_adder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        s_tvalid, s_tlast, m_tready;
  logic [31:0] s_tdata;
  logic [1:0]  s_tid;
  logic [3:0]  s_tdest;
  logic        AXIS_S_TREADY, AXIS_M_TVALID, AXIS_M_TLAST, OVF;
  logic [31:0] AXIS_M_TDATA;
  logic [1:0]  AXIS_M_TID;
  logic [3:0]  AXIS_M_TDEST;
  logic [15:0] RESULT_CNT, DROP_CNT;

  always #5 CLK = ~CLK;

  axis_pair_adder dut (
    .CLK(CLK), .RST(RST),
    .AXIS_S_TVALID(s_tvalid), .AXIS_S_TREADY(AXIS_S_TREADY), .AXIS_S_TDATA(s_tdata),
    .AXIS_S_TLAST(s_tlast), .AXIS_S_TID(s_tid), .AXIS_S_TDEST(s_tdest),
    .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(m_tready), .AXIS_M_TDATA(AXIS_M_TDATA),
    .AXIS_M_TLAST(AXIS_M_TLAST), .AXIS_M_TID(AXIS_M_TID), .AXIS_M_TDEST(AXIS_M_TDEST),
    .RESULT_CNT(RESULT_CNT), .DROP_CNT(DROP_CNT), .OVF(OVF)
  );

  typedef struct { logic [31:0] data; logic last; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] sum; logic last; } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[20];
  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tot_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] full;
    full = {a[31], a} + {b[31], b};
`ifdef ADDER_SATURATE_EN
    if (full[32] != full[31]) return full[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return full[31:0];
  endfunction

  task automatic push_exp(input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the flit is accepted.
  task automatic send(input logic [1:0] tid, input logic [31:0] data);
    int n = 0;
    s_tvalid = 1'b1;
    s_tid    = tid;
    s_tdata  = data;
    while (!AXIS_S_TREADY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!AXIS_S_TREADY) begin
      tot_cnt++;
      $display("FAIL send_timeout: got tready=0 expected tready=1 within 100 cycles (tid %0d)", tid);
    end else begin
      @(negedge CLK);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST      = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  always begin
    @(negedge CLK);
    #1;
    if (!RST && AXIS_M_TVALID && m_tready) begin
      if (exp_q.size() == 0) begin
        tot_cnt++;
        $display("FAIL unexpected_result: got %0h expected no output", AXIS_M_TDATA);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_data", 64'(AXIS_M_TDATA), 64'(mon_e.data));
        check("result_last", 64'(AXIS_M_TLAST), 64'(mon_e.last));
        check("result_tid", 64'(AXIS_M_TID), 64'd1);
        check("result_tdest", 64'(AXIS_M_TDEST), 64'd3);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] t3_a[5];
  logic [31:0] t3_b[5];

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].a    = 32'(i + 1);
      vecs[i].b    = 32'(2 * (i + 1));
      vecs[i].sum  = 32'(3 * (i + 1));
      vecs[i].last = (i == 15);
    end
    vecs[16] = '{32'hFFFF_FFFB, 32'd3,         32'hFFFF_FFFE, 1'b0};
    vecs[17] = '{32'hFFFF_FF9C, 32'hFFFF_FF38, 32'hFFFF_FED4, 1'b0};
    vecs[18] = '{32'h7FFF_FFF0, 32'h0000_000F, 32'h7FFF_FFFF, 1'b0};
    vecs[19] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    for (int k = 0; k < 5; k++) begin
      t3_a[k] = 32'(1000 * k + 1);
      t3_b[k] = -32'(k + 3);
    end

    RST = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tid = '0; s_tdata = '0; s_tdest = '0; m_tready = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_s_tready", 64'(AXIS_S_TREADY), 64'd0);
    check("rst_m_tvalid", 64'(AXIS_M_TVALID), 64'd0);
    check("rst_m_tdata", 64'(AXIS_M_TDATA), 64'd0);
    check("rst_m_tlast", 64'(AXIS_M_TLAST), 64'd0);
    check("rst_result_cnt", 64'(RESULT_CNT), 64'd0);
    check("rst_drop_cnt", 64'(DROP_CNT), 64'd0);
    check("rst_ovf", 64'(OVF), 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_s_tready", 64'(AXIS_S_TREADY), 64'd1);

    // T1: single pair, latency and header fields
    m_tready = 1'b1;
    send(2'd0, 32'd5);
    send(2'd2, 32'd7);
    check("t1_lat_before", 64'(AXIS_M_TVALID), 64'd0);
    push_exp(32'd12, 1'b0);
    @(negedge CLK);
    check("t1_lat_valid", 64'(AXIS_M_TVALID), 64'd1);
    drain("t1_drain");
    check("t1_result_cnt", 64'(RESULT_CNT), 64'd1);

    // T2: table of interleaved pairs, TLAST on the 16th result
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(2'd0, vecs[i].a);
      send(2'd2, vecs[i].b);
      push_exp(vecs[i].sum, vecs[i].last);
    end
    drain("t2_drain");
    check("t2_result_cnt", 64'(RESULT_CNT), 64'd20);
    check("t2_ovf", 64'(OVF), 64'd0);

    // T3: full A FIFO stalls input, held output stays stable, then back-to-back drain
    do_reset();
    for (int k = 0; k < 3; k++) send(2'd0, t3_a[k]);
    send(2'd2, t3_b[0]);
    for (int k = 1; k < 4; k++) send(2'd2, t3_b[k]);
    send(2'd0, t3_a[3]);
    send(2'd0, t3_a[4]);
    for (int k = 0; k < 4; k++) push_exp(model_sum(t3_a[k], t3_b[k]), 1'b0);
    check("t3_full_stall", 64'(AXIS_S_TREADY), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("t3_hold_valid", 64'(AXIS_M_TVALID), 64'd1);
      check("t3_hold_data", 64'(AXIS_M_TDATA), 64'(model_sum(t3_a[0], t3_b[0])));
    end
    check("t3_still_stalled", 64'(AXIS_S_TREADY), 64'd0);
    m_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t3_b2b_valid", 64'(AXIS_M_TVALID), 64'd1);
      @(negedge CLK);
    end
    check("t3_idle_after", 64'(AXIS_M_TVALID), 64'd0);
    check("t3_ready_again", 64'(AXIS_S_TREADY), 64'd1);
    push_exp(model_sum(t3_a[4], t3_b[4]), 1'b0);
    send(2'd2, t3_b[4]);
    drain("t3_drain");
    check("t3_result_cnt", 64'(RESULT_CNT), 64'd5);

    // T4: unknown TIDs are dropped without disturbing pairing
    do_reset();
    m_tready = 1'b1;
    send(2'd0, 32'd10);
    send(2'd3, 32'd99);
    send(2'd1, 32'd55);
    send(2'd2, 32'd20);
    push_exp(32'd30, 1'b0);
    drain("t4_drain");
    check("t4_drop_cnt", 64'(DROP_CNT), 64'd2);
    send(2'd0, 32'd1);
    send(2'd2, 32'd1);
    push_exp(32'd2, 1'b0);
    drain("t4_drain2");
    check("t4_result_cnt", 64'(RESULT_CNT), 64'd2);

    // T5: signed overflow in both directions
    do_reset();
    m_tready = 1'b1;
    check("t5_ovf_clear", 64'(OVF), 64'd0);
    send(2'd0, 32'h7FFF_FFFF);
    send(2'd2, 32'd1);
`ifdef ADDER_SATURATE_EN
    push_exp(32'h7FFF_FFFF, 1'b0);
`else
    push_exp(32'h8000_0000, 1'b0);
`endif
    drain("t5_drain");
    check("t5_ovf_pos", 64'(OVF), 64'd1);
    send(2'd0, 32'h8000_0000);
    send(2'd2, 32'hFFFF_FFFF);
    push_exp(model_sum(32'h8000_0000, 32'hFFFF_FFFF), 1'b0);
    drain("t5_drain2");
    check("t5_ovf_sticky", 64'(OVF), 64'd1);

    // T6: asynchronous reset while a result is held
    do_reset();
    check("t6_ovf_cleared", 64'(OVF), 64'd0);
    m_tready = 1'b1;
    send(2'd0, 32'd1);
    send(2'd2, 32'd2);
    push_exp(32'd3, 1'b0);
    drain("t6_drain");
    send(2'd3, 32'd0);
    m_tready = 1'b0;
    send(2'd0, 32'd11);
    send(2'd2, 32'd22);
    @(negedge CLK);
    check("t6_held_valid", 64'(AXIS_M_TVALID), 64'd1);
    check("t6_held_data", 64'(AXIS_M_TDATA), 64'd33);
    RST = 1'b1;
    #1;
    check("t6_rst_valid", 64'(AXIS_M_TVALID), 64'd0);
    check("t6_rst_data", 64'(AXIS_M_TDATA), 64'd0);
    check("t6_rst_result_cnt", 64'(RESULT_CNT), 64'd0);
    check("t6_rst_drop_cnt", 64'(DROP_CNT), 64'd0);
    check("t6_rst_s_tready", 64'(AXIS_S_TREADY), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    m_tready = 1'b1;
    repeat (10) @(negedge CLK);
    check("t6_no_stale", 64'(AXIS_M_TVALID), 64'd0);
    send(2'd0, 32'd4);
    send(2'd2, 32'd6);
    push_exp(32'd10, 1'b0);
    drain("t6_drain2");
    check("t6_result_cnt", 64'(RESULT_CNT), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
